// File: rtl/lockout_ctrl_if.sv
// Handshake bundle between the lock FSM and the attempt-limiting controller.
interface lockout_ctrl_if;
  logic       attempt_valid;
  logic       attempt_ok;
  logic       backdoor_clr;
  logic       entry_allow;
  logic       lockout;
  logic [3:0] tries_left;
  logic [7:0] secs_left;
  logic [1:0] level;
  logic       tick_1hz;
  logic       blink;

  modport master (
    output attempt_valid, attempt_ok, backdoor_clr,
    input  entry_allow, lockout, tries_left,
    input  secs_left, level, tick_1hz, blink
  );

  modport slave (
    input  attempt_valid, attempt_ok, backdoor_clr,
    output entry_allow, lockout, tries_left,
    output secs_left, level, tick_1hz, blink
  );
endinterface

// File: rtl/lockout_ctrl.sv
// Attempt limiter: counts failed submissions and enforces an
// escalating timed lockout, plus the 1 Hz tick/blink for the display.
module lockout_ctrl #(
  parameter int CLK_HZ      = 50000000,
  parameter int MAX_TRIES   = 3,
  parameter int LOCKOUT_SEC = 10
) (
  input logic           clk,
  input logic           rst,
  lockout_ctrl_if.slave bus
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PS_MAX  = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PS_HALF = PW'(CLK_HZ / 2);
  localparam logic [3:0] TRIES_INIT = 4'(MAX_TRIES);
  localparam logic [7:0] BASE_SEC   = 8'(LOCKOUT_SEC);

  typedef enum logic {ST_ARMED, ST_LOCKOUT} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          blink_q, blink_d;
  logic          entry_q, entry_d;
  logic          lock_q, lock_d;
  logic [3:0]    tries_q, tries_d;
  logic [7:0]    secs_q, secs_d;
  logic [1:0]    level_q, level_d;
  logic          wrap;

  always_comb begin
    wrap    = (presc_q == PS_MAX);
    presc_d = wrap ? '0 : presc_q + 1'b1;
    state_d = state_q;
    entry_d = entry_q;
    lock_d  = lock_q;
    tries_d = tries_q;
    secs_d  = secs_q;
    level_d = level_q;
    if (bus.backdoor_clr) begin
      state_d = ST_ARMED;
      entry_d = 1'b1;
      lock_d  = 1'b0;
      tries_d = TRIES_INIT;
      secs_d  = '0;
      level_d = '0;
    end else begin
      unique case (state_q)
        ST_ARMED: begin
          if (bus.attempt_valid) begin
            if (bus.attempt_ok) begin
              tries_d = TRIES_INIT;
              level_d = '0;
            end else if (tries_q > 4'd1) begin
              tries_d = tries_q - 4'd1;
            end else begin
              // restart the second so the first lockout second is full
              presc_d = '0;
              state_d = ST_LOCKOUT;
              entry_d = 1'b0;
              lock_d  = 1'b1;
              tries_d = '0;
              secs_d  = BASE_SEC << level_q;
              level_d = (level_q == 2'd3) ? 2'd3 : level_q + 2'd1;
            end
          end
        end
        ST_LOCKOUT: begin
          if (wrap) begin
            if (secs_q == 8'd1) begin
              state_d = ST_ARMED;
              entry_d = 1'b1;
              lock_d  = 1'b0;
              tries_d = TRIES_INIT;
              secs_d  = '0;
            end else begin
              secs_d = secs_q - 8'd1;
            end
          end
        end
        default: state_d = ST_ARMED;
      endcase
    end
    tick_d  = wrap;
    blink_d = (presc_d < PS_HALF);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_ARMED;
      presc_q <= '0;
      tick_q  <= 1'b0;
      blink_q <= 1'b1;
      entry_q <= 1'b1;
      lock_q  <= 1'b0;
      tries_q <= TRIES_INIT;
      secs_q  <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      blink_q <= blink_d;
      entry_q <= entry_d;
      lock_q  <= lock_d;
      tries_q <= tries_d;
      secs_q  <= secs_d;
      level_q <= level_d;
    end
  end

  assign bus.entry_allow = entry_q;
  assign bus.lockout     = lock_q;
  assign bus.tries_left  = tries_q;
  assign bus.secs_left   = secs_q;
  assign bus.level       = level_q;
  assign bus.tick_1hz    = tick_q;
  assign bus.blink       = blink_q;

endmodule

// File: tb/tb_lockout_ctrl.sv
// Directed bench for lockout_ctrl with CLK_HZ=10; expected output
// snapshots are queued with each stimulus step and popped after the edge.
module tb_lockout_ctrl;

  logic clk;
  logic rst;

  lockout_ctrl_if bus ();

  lockout_ctrl #(
    .CLK_HZ     (10),
    .MAX_TRIES  (3),
    .LOCKOUT_SEC(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       entry;
    logic       lock;
    logic [3:0] tries;
    logic [7:0] secs;
    logic [1:0] lvl;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic push(input string tag, input logic en, input logic lk,
                      input int tr, input int sc, input int lv);
    exp_t e;
    e.tag   = tag;
    e.entry = en;
    e.lock  = lk;
    e.tries = 4'(tr);
    e.secs  = 8'(sc);
    e.lvl   = 2'(lv);
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, ".entry"}, 8'(bus.entry_allow), 8'(e.entry));
      chk({e.tag, ".lock"}, 8'(bus.lockout), 8'(e.lock));
      chk({e.tag, ".tries"}, 8'(bus.tries_left), 8'(e.tries));
      chk({e.tag, ".secs"}, bus.secs_left, e.secs);
      chk({e.tag, ".level"}, 8'(bus.level), 8'(e.lvl));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic attempt(input logic ok);
    bus.attempt_valid = 1'b1;
    bus.attempt_ok    = ok;
    cyc();
    bus.attempt_valid = 1'b0;
    bus.attempt_ok    = 1'b0;
  endtask

  task automatic do_fails(input int s, input int lv0, input int lv1);
    push("fail1", 1, 0, 2, 0, lv0);
    attempt(1'b0);
    check_sb();
    push("fail2", 1, 0, 1, 0, lv0);
    attempt(1'b0);
    check_sb();
    push("lock_in", 0, 1, 0, s, lv1);
    attempt(1'b0);
    check_sb();
  endtask

  task automatic do_expire(input int s, input int lv);
    repeat (s * 10 - 1) cyc();
    push("last_sec", 0, 1, 0, 1, lv);
    check_sb();
    push("expired", 1, 0, 3, 0, lv);
    cyc();
    check_sb();
  endtask

  initial begin
    rst = 1'b0;
    bus.attempt_valid = 1'b0;
    bus.attempt_ok    = 1'b0;
    bus.backdoor_clr  = 1'b0;

    repeat (3) cyc();
    push("reset", 1, 0, 3, 0, 0);
    check_sb();
    chk("reset.tick", 8'(bus.tick_1hz), 8'd0);
    chk("reset.blink", 8'(bus.blink), 8'd1);

    // prescaler: tick on every 10th edge, blink high for first 5
    rst = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      cyc();
      chk($sformatf("tick%0d", k), 8'(bus.tick_1hz),
          8'((k % 10) == 0));
      chk($sformatf("blink%0d", k), 8'(bus.blink),
          8'((k % 10) < 5));
    end

    push("cnt_f1", 1, 0, 2, 0, 0);
    attempt(1'b0);
    check_sb();
    push("cnt_f2", 1, 0, 1, 0, 0);
    attempt(1'b0);
    check_sb();
    push("cnt_ok", 1, 0, 3, 0, 0);
    attempt(1'b1);
    check_sb();

    do_fails(10, 0, 1);
    push("lk1_9", 0, 1, 0, 9, 1);
    repeat (10) cyc();
    check_sb();
    push("ign_bad", 0, 1, 0, 9, 1);
    attempt(1'b0);
    check_sb();
    push("ign_ok", 0, 1, 0, 9, 1);
    attempt(1'b1);
    check_sb();
    repeat (87) cyc();
    push("lk1_1", 0, 1, 0, 1, 1);
    check_sb();
    // attempt on the expiry edge must be ignored
    push("lk1_exp", 1, 0, 3, 0, 1);
    attempt(1'b0);
    check_sb();

    do_fails(20, 1, 2);
    do_expire(20, 2);
    do_fails(40, 2, 3);
    do_expire(40, 3);
    do_fails(80, 3, 3);
    do_expire(80, 3);

    do_fails(80, 3, 3);
    repeat (730) cyc();
    push("bd_pre", 0, 1, 0, 7, 3);
    check_sb();
    push("bd_clr", 1, 0, 3, 0, 0);
    bus.backdoor_clr  = 1'b1;
    bus.attempt_valid = 1'b1;
    cyc();
    bus.backdoor_clr  = 1'b0;
    bus.attempt_valid = 1'b0;
    check_sb();

    do_fails(10, 0, 1);
    do_expire(10, 1);
    do_fails(20, 1, 2);
    repeat (50) cyc();
    push("rst_pre", 0, 1, 0, 15, 2);
    check_sb();
    push("rst_mid", 1, 0, 3, 0, 0);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    check_sb();
    chk("rst_mid.tick", 8'(bus.tick_1hz), 8'd0);
    chk("rst_mid.blink", 8'(bus.blink), 8'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
